// File: rtl/prog_truth_table.sv
// Programmable multi-output truth table. It evaluates single input vectors with
// one-cycle latency, or sweeps every input combination and streams one result per cycle.
module prog_truth_table #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [N_IN-1:0]  load_addr,
  input  logic [N_OUT-1:0] load_data,
  output logic             load_ready,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in,
  input  logic             sweep_start,
  output logic             busy,
  output logic             out_valid,
  output logic [N_OUT-1:0] out,
  output logic [N_IN-1:0]  out_addr,
  output logic             sweep_done
);

  localparam int unsigned DEPTH = 1 << N_IN;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t           state;
  logic [N_IN-1:0]  cnt;
  logic [N_OUT-1:0] tbl [DEPTH];

  assign busy       = (state == SWEEP);
  assign load_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out        <= '0;
      out_addr   <= '0;
      out_valid  <= 1'b0;
      sweep_done <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      out_valid  <= 1'b0;
      sweep_done <= 1'b0;
      if (state == IDLE) begin
        // The evaluate reads the pre-edge table, so a same-cycle load of the same entry returns the old contents.
        if (in_valid) begin
          out       <= tbl[in];
          out_addr  <= in;
          out_valid <= 1'b1;
        end
        if (load_valid) begin
          tbl[load_addr] <= load_data;
        end
        if (sweep_start) begin
          cnt   <= '0;
          state <= SWEEP;
        end
      end else begin
        out       <= tbl[cnt];
        out_addr  <= cnt;
        out_valid <= 1'b1;
        cnt       <= cnt + 1'b1;
        if (cnt == '1) begin
          sweep_done <= 1'b1;
          state      <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_truth_table.sv
// Scoreboard bench for prog_truth_table: the driver pushes expected results from an
// array model of the table, and a negedge monitor pops and compares each DUT result.
module tb_prog_truth_table;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic [N_IN-1:0]  load_addr = '0;
  logic [N_OUT-1:0] load_data = '0;
  logic             load_ready;
  logic             in_valid = 1'b0;
  logic [N_IN-1:0]  in = '0;
  logic             sweep_start = 1'b0;
  logic             busy;
  logic             out_valid;
  logic [N_OUT-1:0] out;
  logic [N_IN-1:0]  out_addr;
  logic             sweep_done;

  prog_truth_table #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready),
    .in_valid   (in_valid),
    .in         (in),
    .sweep_start(sweep_start),
    .busy       (busy),
    .out_valid  (out_valid),
    .out        (out),
    .out_addr   (out_addr),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  // Expected result: {addr, data, done}
  typedef struct packed {
    logic [N_IN-1:0]  addr;
    logic [N_OUT-1:0] data;
    logic             done;
  } exp_t;

  exp_t             sbq[$];
  logic [N_OUT-1:0] mdl [DEPTH];
  int               rem = 0;      // sweep result cycles still owed
  int               errors = 0;
  int               checks = 0;
  logic [N_OUT-1:0] last_out = '0;
  logic [N_IN-1:0]  last_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_out  = '0;
      last_addr = '0;
    end else if (out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got addr %0h data %0h done %0b expected none at %0t",
                 out_addr, out, sweep_done, $time);
      end else begin
        e = sbq.pop_front();
        chk("out_addr", out_addr, e.addr);
        chk("out", out, e.data);
        chk("sweep_done", sweep_done, e.done);
      end
      last_out  = out;
      last_addr = out_addr;
    end else begin
      chk("hold_out", out, last_out);
      chk("hold_addr", out_addr, last_addr);
      chk("done_without_valid", sweep_done, 1'b0);
    end
  end

  // One cycle of stimulus: apply inputs after a negedge, update the model, wait for the next negedge.
  task automatic drive(input bit lv, input logic [N_IN-1:0] la, input logic [N_OUT-1:0] ld,
                       input bit iv, input logic [N_IN-1:0] ia, input bit ss);
    load_valid  = lv;
    load_addr   = la;
    load_data   = ld;
    in_valid    = iv;
    in          = ia;
    sweep_start = ss;
    chk("busy", busy, rem > 0);
    chk("load_ready", load_ready, rem == 0);
    if (rem > 0) begin
      rem--;
    end else begin
      if (iv) sbq.push_back({ia, mdl[ia], 1'b0});
      if (lv) mdl[la] = ld;
      if (ss) begin
        for (int i = 0; i < DEPTH; i++) begin
          logic [N_IN-1:0] a;
          a = N_IN'(i);
          sbq.push_back({a, mdl[a], (i == DEPTH - 1) ? 1'b1 : 1'b0});
        end
        rem = DEPTH;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, '0, 0);
  endtask

  task automatic eval(input logic [N_IN-1:0] a);
    drive(0, '0, '0, 1, a, 0);
  endtask

  task automatic load(input logic [N_IN-1:0] a, input logic [N_OUT-1:0] d);
    drive(1, a, d, 0, '0, 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out"}, out, '0);
    chk({tag, "_out_addr"}, out_addr, '0);
    chk({tag, "_sweep_done"}, sweep_done, 1'b0);
    chk({tag, "_load_ready"}, load_ready, 1'b1);
  endtask

  task automatic apply_reset(input string tag);
    #2;
    rst         = 1'b1;
    load_valid  = 1'b0;
    in_valid    = 1'b0;
    sweep_start = 1'b0;
    #1;
    reset_checks(tag);
    sbq.delete();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    rem = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

    // Power-on reset values
    #1;
    reset_checks("por");
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Cleared table read
    eval(4'hF);
    idle();

    // Load / evaluate back-to-back
    load(4'd5, 3'b101);
    load(4'd10, 3'b011);
    eval(4'd5);
    eval(4'd10);
    eval(4'd0);
    idle();

    // Read-before-write
    load(4'd3, 3'b001);
    drive(1, 4'd3, 3'b110, 1, 4'd3, 0);
    eval(4'd3);
    idle();

    // Full sweep of i mod 8
    for (int i = 0; i < DEPTH; i++) load(N_IN'(i), N_OUT'(i % 8));
    drive(0, '0, '0, 0, '0, 1);
    for (int i = 0; i < DEPTH; i++) idle();
    idle();

    // Lockout: loads, evaluates and restarts during a sweep are ignored
    drive(0, '0, '0, 0, '0, 1);
    for (int i = 0; i < DEPTH; i++) drive(1, 4'd2, 3'b111, 1, N_IN'($urandom), 1);
    idle();
    eval(4'd2);
    idle();

    // Reset after the 6th sweep result
    drive(0, '0, '0, 0, '0, 1);
    for (int i = 0; i < 6; i++) idle();
    #2;
    chk("results_before_reset", sbq.size(), DEPTH - 6);
    apply_reset("mid_sweep");
    eval(4'd4);
    idle();
    idle();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 3) == 0, N_IN'($urandom), N_OUT'($urandom),
            ($urandom % 2) == 0, N_IN'($urandom), ($urandom % 25) == 0);
    end
    for (int n = 0; n < DEPTH + 4; n++) idle();

    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
